// File: rtl/phy_rx_packet_parser_if.sv
// Symbol stream from the BMC decoder and the framed packet/payload outputs to the protocol layer.
interface phy_rx_packet_parser_if;
  logic       phy_bmc_decoder_active;
  logic       phy_bmc_decoder_data_en;
  logic [4:0] phy_bmc_decoder_data;
  logic [7:0] phy2pl_rx_payload;
  logic       phy2pl_rx_payload_en;
  logic       phy_rx_packet_start;
  logic [2:0] phy_rx_packet_type;
  logic       phy_rx_packet_done;
  logic       phy_rx_packet_err;
  logic [7:0] phy_rx_packet_len;

  modport master (
    output phy_bmc_decoder_active, phy_bmc_decoder_data_en, phy_bmc_decoder_data,
    input  phy2pl_rx_payload, phy2pl_rx_payload_en, phy_rx_packet_start,
           phy_rx_packet_type, phy_rx_packet_done, phy_rx_packet_err, phy_rx_packet_len
  );

  modport slave (
    input  phy_bmc_decoder_active, phy_bmc_decoder_data_en, phy_bmc_decoder_data,
    output phy2pl_rx_payload, phy2pl_rx_payload_en, phy_rx_packet_start,
           phy_rx_packet_type, phy_rx_packet_done, phy_rx_packet_err, phy_rx_packet_len
  );
endinterface

// File: rtl/phy_rx_packet_parser.sv
// USB PD receive framer: ordered-set detection, 4b5b decode, CRC-32 check, and payload
// streaming with the trailing CRC bytes withheld by a 4-byte delay line. All outputs registered.
module phy_rx_packet_parser #(
  parameter int MAX_BYTES = 34
) (
  input logic                   clk,
  input logic                   rst,
  phy_rx_packet_parser_if.slave bus
);

  localparam logic [4:0]  SYM_S1 = 5'b11000;
  localparam logic [4:0]  SYM_S2 = 5'b10001;
  localparam logic [4:0]  SYM_S3 = 5'b00110;
  localparam logic [4:0]  SYM_R1 = 5'b00111;
  localparam logic [4:0]  SYM_R2 = 5'b11001;
  localparam logic [4:0]  SYM_EOP = 5'b01101;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUAL = 32'hDEBB_20E3;

  // Ordered sets packed with K0 in the low 5 bits, matching rx_set below.
  localparam logic [19:0] SET_SOP  = {SYM_S2, SYM_S1, SYM_S1, SYM_S1};
  localparam logic [19:0] SET_SOP1 = {SYM_S3, SYM_S3, SYM_S1, SYM_S1};
  localparam logic [19:0] SET_SOP2 = {SYM_S3, SYM_S1, SYM_S3, SYM_S1};
  localparam logic [19:0] SET_HRST = {SYM_R2, SYM_R1, SYM_R1, SYM_R1};
  localparam logic [19:0] SET_CRST = {SYM_S3, SYM_R1, SYM_S1, SYM_R1};

  typedef enum logic [1:0] {RX_IDLE, RX_SOP, RX_DATA, RX_DROP} state_t;

  state_t          state_q;
  logic [2:0][4:0] k_q;
  logic [1:0]      k_cnt_q;
  logic [3:0]      nib_lo_q;
  logic            nib_odd_q;
  logic [7:0]      byte_cnt_q;
  logic [31:0]     crc_q;
  logic [3:0][7:0] dly_q;
  logic [2:0]      dly_cnt_q;
  logic [7:0]      payload_q;
  logic            payload_en_q;
  logic            start_q;
  logic [2:0]      type_q;
  logic            done_q;
  logic            err_q;
  logic [7:0]      len_q;

  logic [4:0]  sym;
  logic        active;
  logic        data_en;
  logic [19:0] rx_set;
  logic        dec_vld;
  logic [3:0]  dec_nib;
  logic [31:0] crc_d;
  logic [7:0]  byte_d;
  logic [7:0]  len_d;
  logic        eop_good;
  logic        sop_hit_d;
  logic [2:0]  sop_type_d;

  function automatic logic [4:0] dec_4b5b(input logic [4:0] s);
    case (s)
      5'b11110: return 5'h10;
      5'b01001: return 5'h11;
      5'b10100: return 5'h12;
      5'b10101: return 5'h13;
      5'b01010: return 5'h14;
      5'b01011: return 5'h15;
      5'b01110: return 5'h16;
      5'b01111: return 5'h17;
      5'b10010: return 5'h18;
      5'b10011: return 5'h19;
      5'b10110: return 5'h1A;
      5'b10111: return 5'h1B;
      5'b11010: return 5'h1C;
      5'b11011: return 5'h1D;
      5'b11100: return 5'h1E;
      5'b11101: return 5'h1F;
      default:  return 5'h00;
    endcase
  endfunction

  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r >> 1) ^ ((r[0] ^ n[i]) ? CRC_POLY : 32'd0);
    end
    return r;
  endfunction

  function automatic logic [2:0] set_score(input logic [19:0] ref_set, input logic [19:0] rx);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (ref_set[i*5 +: 5] == rx[i*5 +: 5]) s = s + 3'd1;
    end
    return s;
  endfunction

  assign sym      = bus.phy_bmc_decoder_data;
  assign active   = bus.phy_bmc_decoder_active;
  assign data_en  = bus.phy_bmc_decoder_data_en;
  assign rx_set   = {sym, k_q};
  assign {dec_vld, dec_nib} = dec_4b5b(sym);
  assign crc_d    = crc_nibble(crc_q, dec_nib);
  assign byte_d   = {dec_nib, nib_lo_q};
  assign len_d    = (byte_cnt_q >= 8'd4) ? byte_cnt_q - 8'd4 : 8'd0;
  assign eop_good = !nib_odd_q && (byte_cnt_q >= 8'd4) && (crc_q == CRC_RESIDUAL);

  // Any two ordered sets differ in at least two positions, so the first set scoring
  // three or more is also the best match; the if-chain order gives the tie priority.
  always_comb begin
    sop_hit_d  = 1'b1;
    sop_type_d = 3'd0;
    if      (set_score(SET_SOP,  rx_set) >= 3'd3) sop_type_d = 3'd0;
    else if (set_score(SET_SOP1, rx_set) >= 3'd3) sop_type_d = 3'd1;
    else if (set_score(SET_SOP2, rx_set) >= 3'd3) sop_type_d = 3'd2;
    else if (set_score(SET_HRST, rx_set) >= 3'd3) sop_type_d = 3'd3;
    else if (set_score(SET_CRST, rx_set) >= 3'd3) sop_type_d = 3'd4;
    else                                          sop_hit_d  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      k_q          <= '0;
      k_cnt_q      <= 2'd0;
      nib_lo_q     <= 4'd0;
      nib_odd_q    <= 1'b0;
      byte_cnt_q   <= 8'd0;
      crc_q        <= CRC_INIT;
      dly_q        <= '0;
      dly_cnt_q    <= 3'd0;
      payload_q    <= 8'd0;
      payload_en_q <= 1'b0;
      start_q      <= 1'b0;
      type_q       <= 3'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      len_q        <= 8'd0;
    end else begin
      payload_en_q <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (active && data_en) begin
            k_q     <= {sym, k_q[2:1]};
            k_cnt_q <= 2'd1;
            state_q <= RX_SOP;
          end
        end
        RX_SOP: begin
          if (!active) begin
            state_q <= RX_IDLE;
          end else if (data_en) begin
            if (k_cnt_q != 2'd3) begin
              k_q     <= {sym, k_q[2:1]};
              k_cnt_q <= k_cnt_q + 2'd1;
            end else if (!sop_hit_d) begin
              state_q <= RX_DROP;
            end else begin
              start_q <= 1'b1;
              type_q  <= sop_type_d;
              if (sop_type_d >= 3'd3) begin
                done_q  <= 1'b1;
                len_q   <= 8'd0;
                state_q <= RX_DROP;
              end else begin
                nib_odd_q  <= 1'b0;
                byte_cnt_q <= 8'd0;
                dly_cnt_q  <= 3'd0;
                crc_q      <= CRC_INIT;
                state_q    <= RX_DATA;
              end
            end
          end
        end
        RX_DATA: begin
          if (!active) begin
            err_q   <= 1'b1;
            len_q   <= len_d;
            state_q <= RX_IDLE;
          end else if (data_en) begin
            if (dec_vld) begin
              crc_q     <= crc_d;
              nib_odd_q <= !nib_odd_q;
              if (!nib_odd_q) begin
                nib_lo_q <= dec_nib;
              end else if (int'(byte_cnt_q) >= MAX_BYTES) begin
                err_q   <= 1'b1;
                len_q   <= len_d;
                state_q <= RX_DROP;
              end else begin
                byte_cnt_q <= byte_cnt_q + 8'd1;
                dly_q      <= {dly_q[2:0], byte_d};
                // Line already holds four bytes: the oldest one cannot be CRC, release it.
                if (dly_cnt_q == 3'd4) begin
                  payload_q    <= dly_q[3];
                  payload_en_q <= 1'b1;
                end else begin
                  dly_cnt_q <= dly_cnt_q + 3'd1;
                end
              end
            end else if (sym == SYM_EOP) begin
              done_q  <= eop_good;
              err_q   <= !eop_good;
              len_q   <= len_d;
              state_q <= RX_DROP;
            end else begin
              err_q   <= 1'b1;
              len_q   <= len_d;
              state_q <= RX_DROP;
            end
          end
        end
        RX_DROP: begin
          if (!active) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.phy2pl_rx_payload    = payload_q;
  assign bus.phy2pl_rx_payload_en = payload_en_q;
  assign bus.phy_rx_packet_start  = start_q;
  assign bus.phy_rx_packet_type   = type_q;
  assign bus.phy_rx_packet_done   = done_q;
  assign bus.phy_rx_packet_err    = err_q;
  assign bus.phy_rx_packet_len    = len_q;

endmodule

// File: tb/tb_phy_rx_packet_parser.sv
// Bench for phy_rx_packet_parser: directed and random symbol streams checked against a
// packet-level reference model (classify, decode, CRC) kept in the bench.
module tb_phy_rx_packet_parser;
  localparam int MAX_BYTES = 34;
  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOP = 5'b01101;
  localparam logic [4:0] ENC [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                      5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                      5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                      5'b11010, 5'b11011, 5'b11100, 5'b11101};
  localparam logic [4:0] SETS [5][4] = '{'{S1, S1, S1, S2}, '{S1, S1, S3, S3},
                                         '{S1, S3, S1, S3}, '{R1, R1, R1, R2},
                                         '{R1, S1, R1, S3}};

  typedef logic [7:0] byteq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phy_rx_packet_parser_if bus();
  phy_rx_packet_parser #(.MAX_BYTES(MAX_BYTES)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0, miscompares = 0;
  int max_gap = 2;

  logic [4:0] tx_q[$];
  int         sym_cyc[$];

  // Observed behaviour, gathered away from the active edge.
  int         cyc = 0, n_start, n_done, n_err, n_viol, start_cyc, end_cyc;
  logic [2:0] obs_type;
  logic [7:0] obs_len;
  logic [7:0] obs_pay[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.phy_rx_packet_start) begin n_start++; obs_type = bus.phy_rx_packet_type; start_cyc = cyc; end
    if (bus.phy_rx_packet_done) begin n_done++; obs_len = bus.phy_rx_packet_len; end_cyc = cyc; end
    if (bus.phy_rx_packet_err) begin n_err++; obs_len = bus.phy_rx_packet_len; end_cyc = cyc; end
    if (bus.phy2pl_rx_payload_en) obs_pay.push_back(bus.phy2pl_rx_payload);
    if ((bus.phy_rx_packet_done && bus.phy_rx_packet_err) ||
        (bus.phy_rx_packet_start && bus.phy2pl_rx_payload_en)) n_viol++;
  end

  // Expected behaviour from the reference model.
  bit         exp_start, exp_done, exp_err, exp_len_vld;
  logic [2:0] exp_type;
  logic [7:0] exp_len;
  logic [7:0] exp_pay[$];

  function automatic int decode(input logic [4:0] s);
    for (int i = 0; i < 16; i++) if (ENC[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [31:0] crc32(input byteq_t q);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) for (int b = 0; b < 8; b++)
      c = (c[0] ^ q[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return ~c;
  endfunction

  task automatic model();
    int t, n, nib_cnt, d;
    logic [3:0] lo;
    logic [7:0] bytes[$];
    logic [7:0] body[$];
    bit term, eop;
    exp_start = 0; exp_done = 0; exp_err = 0; exp_len_vld = 0; exp_len = 0; exp_pay.delete();
    lo = 4'd0;
    if (tx_q.size() < 4) return;
    t = -1;
    for (int i = 0; i < 5 && t < 0; i++) begin
      n = 0;
      for (int j = 0; j < 4; j++) if (tx_q[j] == SETS[i][j]) n++;
      if (n >= 3) t = i;
    end
    if (t < 0) return;
    exp_start = 1; exp_type = 3'(t);
    if (t >= 3) begin exp_done = 1; exp_len_vld = 1; return; end
    nib_cnt = 0; term = 0; eop = 0;
    for (int i = 4; i < tx_q.size() && !term; i++) begin
      d = decode(tx_q[i]);
      if (d >= 0) begin
        if (nib_cnt % 2 == 0) lo = 4'(d);
        else if (bytes.size() == MAX_BYTES) term = 1;
        else bytes.push_back({4'(d), lo});
        nib_cnt++;
      end else begin
        term = 1; eop = (tx_q[i] == EOP);
      end
    end
    n = (bytes.size() >= 4) ? bytes.size() - 4 : 0;
    for (int i = 0; i < n; i++) begin exp_pay.push_back(bytes[i]); body.push_back(bytes[i]); end
    if (eop) begin
      exp_len = 8'(n); exp_len_vld = 1;
      if (nib_cnt % 2 == 0 && bytes.size() >= 4 &&
          crc32(body) == {bytes[n+3], bytes[n+2], bytes[n+1], bytes[n]}) exp_done = 1;
      else exp_err = 1;
    end else begin
      exp_err = 1;
    end
  endtask

  function automatic bit pay_match();
    if (obs_pay.size() != exp_pay.size()) return 0;
    foreach (exp_pay[i]) if (obs_pay[i] !== exp_pay[i]) return 0;
    return 1;
  endfunction

  task automatic add_sop(input int t);
    for (int j = 0; j < 4; j++) tx_q.push_back(SETS[t][j]);
  endtask

  task automatic add_byte(input logic [7:0] b);
    tx_q.push_back(ENC[b[3:0]]);
    tx_q.push_back(ENC[b[7:4]]);
  endtask

  task automatic add_known_body(input logic [7:0] third);
    for (int i = 0; i < 9; i++) add_byte((i == 2) ? third : 8'(8'h31 + i));
    add_byte(8'h26); add_byte(8'h39); add_byte(8'hF4); add_byte(8'hCB);
    tx_q.push_back(EOP);
  endtask

  task automatic drive_sym(input logic [4:0] s);
    bus.phy_bmc_decoder_data = s;
    bus.phy_bmc_decoder_data_en = 1'b1;
    sym_cyc.push_back(cyc);
    @(posedge clk); #1;
    bus.phy_bmc_decoder_data_en = 1'b0;
    repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    n_start = 0; n_done = 0; n_err = 0; n_viol = 0; obs_pay.delete(); sym_cyc.delete();
    start_cyc = -1; end_cyc = -1;
  endtask

  task automatic run_packet();
    clear_mon();
    bus.phy_bmc_decoder_active = 1'b1;
    @(posedge clk); #1;
    foreach (tx_q[i]) drive_sym(tx_q[i]);
    repeat (2) begin @(posedge clk); #1; end
    bus.phy_bmc_decoder_active = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if ({bus.phy2pl_rx_payload, bus.phy2pl_rx_payload_en, bus.phy_rx_packet_start, bus.phy_rx_packet_type,
         bus.phy_rx_packet_done, bus.phy_rx_packet_err, bus.phy_rx_packet_len} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got payload=%h en=%b start=%b type=%0d done=%b err=%b len=%0d, want all 0",
               bus.phy2pl_rx_payload, bus.phy2pl_rx_payload_en, bus.phy_rx_packet_start, bus.phy_rx_packet_type,
               bus.phy_rx_packet_done, bus.phy_rx_packet_err, bus.phy_rx_packet_len);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_known_packet();
    tx_q.delete(); add_sop(0); add_known_body(8'h33);
    run_packet();
    vectors++;
    if (n_start !== 1 || obs_type !== 3'd0) begin
      miscompares++; $display("FAIL known_start: starts=%0d type=%0d, want 1 and 0", n_start, obs_type);
    end
    vectors++;
    if (start_cyc !== sym_cyc[3] + 2 || end_cyc !== sym_cyc[sym_cyc.size()-1] + 2) begin
      miscompares++;
      $display("FAIL known_latency: start at +%0d, done at +%0d cycles, want +2 and +2",
               start_cyc - sym_cyc[3], end_cyc - sym_cyc[sym_cyc.size()-1]);
    end
    vectors++;
    if (obs_pay.size() !== 9 || obs_pay[0] !== 8'h31 || obs_pay[4] !== 8'h35 || obs_pay[8] !== 8'h39 || !pay_match()) begin
      miscompares++; $display("FAIL known_payload: %0d bytes (in order=%0b), want 9 bytes 31..39", obs_pay.size(), pay_match());
    end
    vectors++;
    if (n_done !== 1 || n_err !== 0 || obs_len !== 8'd9) begin
      miscompares++; $display("FAIL known_done: done=%0d err=%0d len=%0d, want 1 0 9", n_done, n_err, obs_len);
    end
  endtask

  task automatic test_bad_crc();
    tx_q.delete(); add_sop(0); add_known_body(8'h00);
    run_packet();
    vectors++;
    if (obs_pay.size() !== 9 || obs_pay[2] !== 8'h00 || obs_pay[3] !== 8'h34) begin
      miscompares++; $display("FAIL badcrc_payload: %0d bytes, third=%h, want 9 bytes third=00", obs_pay.size(), obs_pay[2]);
    end
    vectors++;
    if (n_done !== 0 || n_err !== 1 || obs_len !== 8'd9) begin
      miscompares++; $display("FAIL badcrc_err: done=%0d err=%0d len=%0d, want 0 1 9", n_done, n_err, obs_len);
    end
  endtask

  task automatic test_kcode_resets();
    for (int t = 3; t <= 4; t++) begin
      tx_q.delete(); add_sop(t); add_byte(8'hA5);
      run_packet();
      vectors++;
      if (n_start !== 1 || n_done !== 1 || n_err !== 0 || obs_type !== 3'(t) ||
          obs_len !== 8'd0 || start_cyc !== end_cyc || obs_pay.size() !== 0) begin
        miscompares++;
        $display("FAIL kcode_type%0d: start=%0d done=%0d err=%0d type=%0d len=%0d same_cycle=%0b pay=%0d, want 1 1 0 %0d 0 1 0",
                 t, n_start, n_done, n_err, obs_type, obs_len, start_cyc == end_cyc, obs_pay.size(), t);
      end
    end
  endtask

  task automatic test_sop_tolerance();
    tx_q.delete(); tx_q.push_back(S1); tx_q.push_back(S1); tx_q.push_back(5'b00000); tx_q.push_back(S2);
    add_known_body(8'h33);
    run_packet();
    vectors++;
    if (n_start !== 1 || obs_type !== 3'd0 || n_done !== 1) begin
      miscompares++; $display("FAIL sop_one_bad: start=%0d type=%0d done=%0d, want 1 0 1", n_start, obs_type, n_done);
    end
    tx_q.delete(); tx_q.push_back(S1); tx_q.push_back(S1); tx_q.push_back(S1); tx_q.push_back(S3);
    add_known_body(8'h33);
    run_packet();
    vectors++;
    if (n_start !== 1 || obs_type !== 3'd0 || n_done !== 1) begin
      miscompares++; $display("FAIL sop_priority: start=%0d type=%0d done=%0d, want 1 0 1", n_start, obs_type, n_done);
    end
    tx_q.delete(); tx_q.push_back(5'b00000); tx_q.push_back(5'b00000); tx_q.push_back(S1); tx_q.push_back(S2);
    add_known_body(8'h33);
    run_packet();
    vectors++;
    if (n_start + n_done + n_err + obs_pay.size() !== 0) begin
      miscompares++; $display("FAIL sop_nomatch: start=%0d done=%0d err=%0d pay=%0d, want no activity",
                              n_start, n_done, n_err, obs_pay.size());
    end
    tx_q.delete(); add_sop(2); add_known_body(8'h33);
    run_packet();
    vectors++;
    if (n_start !== 1 || obs_type !== 3'd2 || n_done !== 1 || obs_len !== 8'd9) begin
      miscompares++; $display("FAIL sop_after_drop: start=%0d type=%0d done=%0d len=%0d, want 1 2 1 9",
                              n_start, obs_type, n_done, obs_len);
    end
  endtask

  task automatic test_errors();
    int kpos;
    tx_q.delete(); add_sop(0); for (int i = 0; i < 3; i++) add_byte(8'(i + 1));
    kpos = tx_q.size(); tx_q.push_back(R1); add_byte(8'h44); tx_q.push_back(EOP);
    run_packet();
    vectors++;
    if (n_err !== 1 || n_done !== 0 || end_cyc !== sym_cyc[kpos] + 2) begin
      miscompares++; $display("FAIL err_kcode: err=%0d done=%0d at +%0d, want 1 0 at +2", n_err, n_done, end_cyc - sym_cyc[kpos]);
    end
    tx_q.delete(); add_sop(1); for (int i = 0; i < 5; i++) add_byte(8'(8'h50 + i));
    run_packet();
    vectors++;
    if (n_err !== 1 || n_done !== 0 || obs_pay.size() !== 1 || obs_pay[0] !== 8'h50) begin
      miscompares++; $display("FAIL err_active_drop: err=%0d done=%0d pay=%0d, want 1 0 1 (50)", n_err, n_done, obs_pay.size());
    end
    tx_q.delete(); add_sop(0); add_known_body(8'h33); tx_q.delete(tx_q.size() - 2);
    run_packet();
    vectors++;
    if (n_err !== 1 || n_done !== 0) begin
      miscompares++; $display("FAIL err_odd_nibble: err=%0d done=%0d, want 1 0", n_err, n_done);
    end
  endtask

  task automatic test_overflow();
    int last;
    tx_q.delete(); add_sop(0);
    for (int i = 0; i < 35; i++) add_byte(8'($urandom));
    last = tx_q.size() - 1;
    for (int i = 0; i < 3; i++) add_byte(8'($urandom));
    tx_q.push_back(EOP);
    run_packet();
    vectors++;
    if (n_err !== 1 || n_done !== 0 || exp_err !== 1'b1 || end_cyc !== sym_cyc[last] + 2) begin
      miscompares++; $display("FAIL overflow_err: err=%0d done=%0d at +%0d, want 1 0 at +2", n_err, n_done, end_cyc - sym_cyc[last]);
    end
    tx_q.delete(); add_sop(0); add_known_body(8'h33);
    run_packet();
    vectors++;
    if (n_start !== 1 || n_done !== 1 || n_err !== 0 || obs_len !== 8'd9 || !pay_match()) begin
      miscompares++; $display("FAIL overflow_recover: start=%0d done=%0d err=%0d len=%0d pay_ok=%0b, want 1 1 0 9 1",
                              n_start, n_done, n_err, obs_len, pay_match());
    end
  endtask

  task automatic test_reset_mid();
    tx_q.delete(); add_sop(1); for (int i = 0; i < 3; i++) add_byte(8'($urandom));
    clear_mon();
    bus.phy_bmc_decoder_active = 1'b1;
    @(posedge clk); #1;
    foreach (tx_q[i]) drive_sym(tx_q[i]);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus.phy2pl_rx_payload_en, bus.phy_rx_packet_start, bus.phy_rx_packet_type,
         bus.phy_rx_packet_done, bus.phy_rx_packet_err, bus.phy_rx_packet_len} !== 15'd0) begin
      miscompares++; $display("FAIL reset_mid_outputs: type=%0d done=%b err=%b len=%0d, want all 0",
                              bus.phy_rx_packet_type, bus.phy_rx_packet_done, bus.phy_rx_packet_err, bus.phy_rx_packet_len);
    end
    rst = 1'b0;
    bus.phy_bmc_decoder_active = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (n_done + n_err !== 0) begin
      miscompares++; $display("FAIL reset_mid_pulses: done=%0d err=%0d, want 0 0", n_done, n_err);
    end
  endtask

  task automatic gen_random(input int mode, input int n);
    logic [7:0] bq[$];
    logic [31:0] c;
    logic [4:0] s;
    int k;
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    c = crc32(bq);
    for (int i = 0; i < 4; i++) bq.push_back(c[8*i +: 8]);
    if (mode == 1) begin k = $urandom_range(0, bq.size() - 1); bq[k] ^= 8'(1 << $urandom_range(0, 7)); end
    tx_q.delete(); add_sop($urandom_range(0, 2));
    foreach (bq[i]) add_byte(bq[i]);
    tx_q.push_back(EOP);
    case (mode)
      2: begin
        do s = 5'($urandom); while (decode(s) >= 0 || s == EOP);
        tx_q.insert($urandom_range(4, tx_q.size() - 1), s);
      end
      3: tx_q.delete(tx_q.size() - 2);
      4: repeat ($urandom_range(1, 3)) void'(tx_q.pop_back());
      5: tx_q[$urandom_range(0, 3)] = 5'b00000;
      default: ;
    endcase
  endtask

  task automatic test_random();
    for (int p = 0; p < 40; p++) begin
      gen_random($urandom_range(0, 5), $urandom_range(0, 30));
      run_packet();
      vectors++;
      if (n_start !== int'(exp_start) || (exp_start && obs_type !== exp_type)) begin
        miscompares++; $display("FAIL rand%0d_start: start=%0d type=%0d, want %0d %0d", p, n_start, obs_type, exp_start, exp_type);
      end
      vectors++;
      if (n_done !== int'(exp_done) || n_err !== int'(exp_err)) begin
        miscompares++; $display("FAIL rand%0d_status: done=%0d err=%0d, want %0d %0d", p, n_done, n_err, exp_done, exp_err);
      end
      if (exp_len_vld) begin
        vectors++;
        if (obs_len !== exp_len) begin
          miscompares++; $display("FAIL rand%0d_len: len=%0d, want %0d", p, obs_len, exp_len);
        end
      end
      vectors++;
      if (!pay_match()) begin
        miscompares++; $display("FAIL rand%0d_payload: %0d bytes, want %0d (content differs or count)", p, obs_pay.size(), exp_pay.size());
      end
      vectors++;
      if (n_viol !== 0) begin
        miscompares++; $display("FAIL rand%0d_exclusive: %0d cycles with done+err or start+payload, want 0", p, n_viol);
      end
    end
  endtask

  task automatic test_back_to_back();
    max_gap = 0;
    for (int p = 0; p < 6; p++) begin
      gen_random(0, $urandom_range(0, 30));
      run_packet();
      vectors++;
      if (n_done !== 1 || n_err !== 0 || obs_len !== exp_len || !pay_match()) begin
        miscompares++; $display("FAIL b2b%0d: done=%0d err=%0d len=%0d pay=%0d, want 1 0 %0d %0d",
                                p, n_done, n_err, obs_len, obs_pay.size(), exp_len, exp_pay.size());
      end
    end
    max_gap = 2;
  endtask

  initial begin
    bus.phy_bmc_decoder_active = 1'b0;
    bus.phy_bmc_decoder_data_en = 1'b0;
    bus.phy_bmc_decoder_data = 5'd0;
    rst = 1'b1;
    #1;
    test_reset();
    test_known_packet();
    test_bad_crc();
    test_kcode_resets();
    test_sop_tolerance();
    test_errors();
    test_overflow();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
